// File: rtl/updown_modn_chain.sv
// Cascaded DIGITS-digit up/down counter, each digit modulo MOD, with wrap/saturate mode,
// terminal-count pulse and zero/max flags. Define UPDOWN_MODN_LOAD_EN to enable the parallel load.
module updown_modn_chain #(
    parameter int MOD    = 10,
    parameter int DIGITS = 2,
    parameter int W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                inc,
    input  logic                dec,
    input  logic                sat,
    input  logic                load,
    input  logic [DIGITS*W-1:0] din,
    output logic [DIGITS*W-1:0] q,
    output logic                tc,
    output logic                zero,
    output logic                max
);

    localparam logic [W-1:0] TOP = W'(MOD - 1);

    logic [W-1:0]    q_reg    [DIGITS];
    logic [W-1:0]    step_val [DIGITS];
    logic [DIGITS:0] carry;
    logic [DIGITS:0] borrow;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_zero;
    logic            tc_reg;
    logic            step_up;
    logic            step_dn;
    logic            crossing;
    logic            hold_sat;

    assign step_up = ena & inc & ~dec;
    assign step_dn = ena & dec & ~inc;

    assign carry[0]  = step_up;
    assign borrow[0] = step_dn;

    // A carry leaving the top digit is a boundary crossing; in saturate mode nothing moves.
    assign crossing = carry[DIGITS] | borrow[DIGITS];
    assign hold_sat = crossing & sat;

`ifdef UPDOWN_MODN_LOAD_EN
    logic [W-1:0] load_val [DIGITS];
`else
    logic unused_load;
    assign unused_load = load ^ (^din);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign at_max[gi]    = (q_reg[gi] == TOP);
            assign at_zero[gi]   = (q_reg[gi] == '0);
            assign carry[gi+1]   = carry[gi] & at_max[gi];
            assign borrow[gi+1]  = borrow[gi] & at_zero[gi];
            assign q[gi*W +: W]  = q_reg[gi];

            always_comb begin
                step_val[gi] = q_reg[gi];
                if (carry[gi]) begin
                    step_val[gi] = at_max[gi] ? '0 : q_reg[gi] + W'(1);
                end else if (borrow[gi]) begin
                    step_val[gi] = at_zero[gi] ? TOP : q_reg[gi] - W'(1);
                end
            end

`ifdef UPDOWN_MODN_LOAD_EN
            // Out-of-range load fields are clamped per digit, never wrapped.
            assign load_val[gi] = (din[gi*W +: W] > TOP) ? TOP : din[gi*W +: W];

            always_ff @(posedge clk) begin
                if (rst) begin
                    q_reg[gi] <= '0;
                end else if (load) begin
                    q_reg[gi] <= load_val[gi];
                end else if (!hold_sat) begin
                    q_reg[gi] <= step_val[gi];
                end
            end
`else
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_reg[gi] <= '0;
                end else if (!hold_sat) begin
                    q_reg[gi] <= step_val[gi];
                end
            end
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            tc_reg <= 1'b0;
`ifdef UPDOWN_MODN_LOAD_EN
        end else if (load) begin
            tc_reg <= 1'b0;
`endif
        end else begin
            tc_reg <= crossing;
        end
    end

    assign tc   = tc_reg;
    assign zero = &at_zero;
    assign max  = &at_max;

endmodule
